restoring_divider: RTL and testbench
====================================

# restoring_divider

Iterative unsigned restoring divider that sits directly downstream of the `subtractor` block and drives it. It loads a dividend/divisor pair on `start` and resolves one quotient bit per clock, using a `subtractor` instance's `result` and `borrow` to decide each restore step. It produces `quotient`, `remainder` and a divide-by-zero flag behind a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 4: operand, quotient and remainder width in bits; legal range is 2 or more.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled on the rising edge; accepted only when `busy`=0.
- `dividend`  input  WIDTH  unsigned dividend; sampled on the accepting edge.
- `divisor`  input  WIDTH  unsigned divisor; sampled on the accepting edge.
- `busy`  output  1  high while iterating.
- `done`  output  1  one-cycle pulse; results valid while it is high.
- `quotient`  output  WIDTH  registered quotient.
- `remainder`  output  WIDTH  registered remainder.
- `div_by_zero`  output  1  registered; set on a zero divisor.

## Operation
- The datapath contains one `subtractor #(WIDTH+1)` instance.
  - Operand a is the shifted partial remainder.
  - Operand b is `{1'b0, divisor_reg}`.
  - `borrow`=1 means the shifted remainder is less than the divisor.
- State machine states: IDLE, RUN, DONE.
- IDLE or DONE, `start`=1, `divisor`≠0:
  - Load dividend into the working Q register; clear the partial remainder R (WIDTH+1 bits).
  - Latch the divisor; set the step counter to WIDTH.
  - Clear `div_by_zero`; go to RUN.
- IDLE or DONE, `start`=1, `divisor`=0:
  - Go directly to DONE, with no RUN.
  - Set `quotient` to all ones, `remainder` to `dividend`, `div_by_zero` to 1.
- RUN, each edge (one step):
  - Shifted remainder S = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left by one.
  - If `borrow`=0: R becomes the subtractor `result` and Q[0] becomes 1.
  - If `borrow`=1: R becomes S (restore) and Q[0] becomes 0.
  - Decrement the counter. On the step where the counter reaches 0:
    - Write Q to `quotient` and R[WIDTH-1:0] to `remainder`.
    - Go to DONE.
- DONE, lasting one cycle:
  - `done`=1.
  - The next edge goes to IDLE, or starts a new operation if `start`=1.
- `start` is ignored in RUN; the operation in flight is unaffected.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next completion or reset.
- Arithmetic is unsigned throughout. Invariant: dividend = quotient×divisor + remainder, with remainder < divisor.

## Timing
- Reset, asserted at any time including mid-RUN:
  - State goes to IDLE immediately.
  - `busy`, `done`, `quotient`, `remainder` and `div_by_zero` all become 0.
  - The operation is aborted and no `done` is produced for it.
- `start` is accepted at edge k.
  - `busy`=1 from just after edge k until edge k+WIDTH.
  - Results update at edge k+WIDTH.
  - `done`=1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
  - Latency is WIDTH cycles.
- Zero divisor accepted at edge k:
  - `done`=1 in the cycle after edge k.
  - `busy` stays 0.
- Back-to-back: `start` during the DONE cycle is accepted, giving a new `busy` at that edge with no idle gap.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- 13 ÷ 3, `WIDTH`=4, `start` accepted at edge k:
  - `busy` high for 4 cycles.
  - `done` in the cycle after edge k+4.
  - `quotient`=4, `remainder`=1, `div_by_zero`=0.
- 7 ÷ 0:
  - `done` in the cycle after the accepting edge; `busy` never high.
  - `quotient`=4'hF, `remainder`=7, `div_by_zero`=1.
- Boundary cases:
  - 15 ÷ 1 gives `quotient`=15, `remainder`=0.
  - 3 ÷ 7 gives `quotient`=0, `remainder`=3.
  - 0 ÷ 5 gives `quotient`=0, `remainder`=0.
  - 15 ÷ 15 gives `quotient`=1, `remainder`=0.
- Start 9 ÷ 2, then pulse `start` with 15 ÷ 4 during RUN:
  - The second request is ignored.
  - Result is `quotient`=4, `remainder`=1; exactly one `done`.
- Start 11 ÷ 3, assert `rst_n`=0 after 2 steps, release, then start 11 ÷ 3 again:
  - After the reset, all outputs are 0 and no `done` appears for the aborted operation.
  - The fresh operation produces `quotient`=3, `remainder`=2.
- Back-to-back: 12 ÷ 5, then `start` with 6 ÷ 4 during its `done` cycle:
  - First result: 2 remainder 2.
  - Second: `done` 4 cycles later, result 1 remainder 2.
- Exhaustive: all 256 `WIDTH`=4 operand pairs.
  - Every nonzero-divisor result is checked against the invariant.
  - Every zero-divisor result is checked against the div-by-zero rule.

Source files
------------

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with the
// restore decision taken from a subtractor's borrow output.

module subtractor #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             borrow
);
   assign {borrow, result} = {1'b0, a} - {1'b0, b};
endmodule

module restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q_reg, dvs_reg, q_next;
   logic [WIDTH:0]   r_reg, shifted, diff, r_next;
   logic [CW-1:0]    cnt;
   logic             borrow;

   // R never exceeds the divisor, so its top bit stays zero and drops out of the shift.
   logic unused_r_msb;
   assign unused_r_msb = r_reg[WIDTH];

   assign shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

   subtractor #(.WIDTH(WIDTH + 1)) u_sub (
      .a      (shifted),
      .b      ({1'b0, dvs_reg}),
      .result (diff),
      .borrow (borrow)
   );

   assign r_next = borrow ? shifted : diff;
   assign q_next = {q_reg[WIDTH-2:0], ~borrow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         q_reg       <= '0;
         r_reg       <= '0;
         dvs_reg     <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               state <= IDLE;
               if (start) begin
                  if (divisor != '0) begin
                     q_reg       <= dividend;
                     r_reg       <= '0;
                     dvs_reg     <= divisor;
                     cnt         <= CW'(WIDTH);
                     div_by_zero <= 1'b0;
                     busy        <= 1'b1;
                     state       <= RUN;
                  end else begin
                     // Zero divisor resolves immediately without iterating.
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            RUN: begin
               q_reg <= q_next;
               r_reg <= r_next;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  quotient  <= q_next;
                  remainder <= r_next[WIDTH-1:0];
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4): directed cases, random
// operands and an exhaustive sweep, all checked against plain integer division.

module tb_restoring_divider;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int n_tests = 0;
   int n_fail  = 0;

   restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive a request and return #1 after the edge that samples it.
   task automatic start_op(input int a, input int b);
      @(negedge clk);
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Called #1 after an accepting edge; counts edges until done shows up.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (1) begin
         if (busy) bcnt++;
         if (done) break;
         if (lat >= 20) begin
            chk("timeout_done", done, 1);
            break;
         end
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic op(input int a, input int b, input string tag);
      int lat, bc, eq, er;
      start_op(a, b);
      wait_done(lat, bc);
      eq = (b == 0) ? (1 << W) - 1 : a / b;
      er = (b == 0) ? a : a % b;
      chk({tag, "_lat"},  lat, (b == 0) ? 0 : W);
      chk({tag, "_busy"}, bc,  (b == 0) ? 0 : W);
      chk({tag, "_q"},    quotient,    eq);
      chk({tag, "_r"},    remainder,   er);
      chk({tag, "_dbz"},  div_by_zero, (b == 0) ? 1 : 0);
      if (b != 0) begin
         chk({tag, "_inv"},  quotient * b + remainder, a);
         chk({tag, "_rltd"}, (remainder < b) ? 1 : 0, 1);
      end
      @(posedge clk);
      #1 chk({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      int lat, bc, dcnt;
      logic [W-1:0] sq, sr;

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk) rst_n = 1'b1;

      op(13, 3, "d13_3");
      op(7, 0, "d7_0");
      op(15, 1, "d15_1");
      op(3, 7, "d3_7");
      op(0, 5, "d0_5");
      op(15, 15, "d15_15");

      // Second start during RUN must be ignored.
      start_op(9, 2);
      @(posedge clk);
      @(negedge clk);
      dividend = 4'd15; divisor = 4'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      dcnt = 0; sq = '0; sr = '0;
      repeat (10) begin
         if (done) begin dcnt++; sq = quotient; sr = remainder; end
         @(posedge clk);
         #1;
      end
      chk("ign_dones", dcnt, 1);
      chk("ign_q", sq, 4);
      chk("ign_r", sr, 1);

      // Reset mid-RUN aborts with no done.
      start_op(11, 3);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_q", quotient, 0);
      chk("abort_r", remainder, 0);
      chk("abort_dbz", div_by_zero, 0);
      dcnt = 0;
      @(negedge clk) rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1 if (done) dcnt++;
      end
      chk("abort_nodone", dcnt, 0);
      op(11, 3, "d11_3");

      // Back-to-back: new start during the DONE cycle.
      start_op(12, 5);
      wait_done(lat, bc);
      chk("b2b1_lat", lat, W);
      chk("b2b1_q", quotient, 2);
      chk("b2b1_r", remainder, 2);
      dividend = 4'd6; divisor = 4'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("b2b2_busy", busy, 1);
      chk("b2b2_done", done, 0);
      wait_done(lat, bc);
      chk("b2b2_lat", lat, W);
      chk("b2b2_q", quotient, 1);
      chk("b2b2_r", remainder, 2);

      for (int i = 0; i < 40; i++)
         op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), "rnd");

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            op(a, b, "exh");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
